// File: rtl/quad_step_sched.sv
// Steering step scheduler: merges a mouse step backlog and joystick holds into one
// Gray quadrature output. Define STEER_ACCEL_EN to enable joystick hold acceleration.
module quad_step_sched #(
  parameter int CNT_W = 8
`ifdef STEER_ACCEL_EN
  , parameter int ACCEL_STEPS = 4
`endif
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [7:0]              clkdiv,
  input  logic                    left,
  input  logic                    right,
  input  logic                    mouse_stb,
  input  logic signed [7:0]       mouse_dx,
  output logic [1:0]              steer,
  output logic signed [CNT_W-1:0] pending,
  output logic                    busy
);

  localparam int SW = ((CNT_W > 8) ? CNT_W : 8) + 2;
  localparam logic signed [SW-1:0] PMAX = {{(SW-CNT_W+1){1'b0}}, {(CNT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] PMIN = -PMAX;

  logic [7:0]              r_cnt;
  logic [1:0]              r_steer;
  logic signed [CNT_W-1:0] r_pending;
  logic                    r_busy;

  logic                    w_tick;
  logic                    w_joyR;
  logic                    w_joyL;
  logic                    w_pendZero;
  logic                    w_bklR;
  logic                    w_bklL;
  logic                    w_bklStep;
  logic                    w_joyStepR;
  logic                    w_joyStepL;
  logic                    w_stepR;
  logic                    w_stepL;
  logic [1:0]              w_stage;
  logic [7:0]              w_reload;
  logic [1:0]              w_steerNext;
  logic signed [SW-1:0]    w_pendExt;
  logic signed [SW-1:0]    w_dxExt;
  logic signed [SW-1:0]    w_bstep;
  logic signed [SW-1:0]    w_sum;
  logic signed [CNT_W-1:0] w_pendNext;

  assign w_tick     = (r_cnt == 8'd0);
  assign w_joyR     = right & ~left;
  assign w_joyL     = left & ~right;
  assign w_pendZero = (r_pending == '0);

  // An outstanding backlog always takes the tick before any joystick step.
  assign w_bklR     = w_tick & ~r_pending[CNT_W-1] & ~w_pendZero;
  assign w_bklL     = w_tick & r_pending[CNT_W-1];
  assign w_bklStep  = w_bklR | w_bklL;
  assign w_joyStepR = w_tick & w_pendZero & w_joyR;
  assign w_joyStepL = w_tick & w_pendZero & w_joyL;
  assign w_stepR    = w_bklR | w_joyStepR;
  assign w_stepL    = w_bklL | w_joyStepL;

`ifdef STEER_ACCEL_EN
  localparam int HOLD_W = $clog2(3*ACCEL_STEPS + 1);
  localparam logic [HOLD_W-1:0] STAGE1_AT = HOLD_W'(ACCEL_STEPS);
  localparam logic [HOLD_W-1:0] STAGE2_AT = HOLD_W'(2*ACCEL_STEPS);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(3*ACCEL_STEPS);

  logic [HOLD_W-1:0] r_hold;
  logic              r_prevR;
  logic              r_prevL;
  logic [HOLD_W-1:0] w_holdBase;
  logic [HOLD_W-1:0] w_holdNext;

  always_comb begin
    w_holdBase = ((w_joyR & r_prevR) | (w_joyL & r_prevL)) ? r_hold : '0;
    w_holdNext = w_holdBase;
    if ((w_joyStepR | w_joyStepL) && (w_holdBase != HOLD_MAX))
      w_holdNext = w_holdBase + 1'b1;
    if (w_bklStep)
      w_holdNext = '0;
  end

  always_comb begin
    w_stage = 2'd0;
    if (!w_bklStep) begin
      if (r_hold >= STAGE2_AT)
        w_stage = 2'd2;
      else if (r_hold >= STAGE1_AT)
        w_stage = 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hold  <= '0;
      r_prevR <= 1'b0;
      r_prevL <= 1'b0;
    end else begin
      r_hold  <= w_holdNext;
      r_prevR <= w_joyR;
      r_prevL <= w_joyL;
    end
  end
`else
  assign w_stage = 2'd0;
`endif

  assign w_reload = clkdiv >> w_stage;

  always_comb begin
    w_steerNext = r_steer;
    if (w_stepR) begin
      case (r_steer)
        2'b00:   w_steerNext = 2'b10;
        2'b10:   w_steerNext = 2'b11;
        2'b11:   w_steerNext = 2'b01;
        default: w_steerNext = 2'b00;
      endcase
    end else if (w_stepL) begin
      case (r_steer)
        2'b00:   w_steerNext = 2'b01;
        2'b01:   w_steerNext = 2'b11;
        2'b11:   w_steerNext = 2'b10;
        default: w_steerNext = 2'b00;
      endcase
    end
  end

  // Wide signed sum so a mouse delta plus a backlog step can never wrap before clamping.
  always_comb begin
    w_pendExt = {{(SW-CNT_W){r_pending[CNT_W-1]}}, r_pending};
    w_dxExt   = mouse_stb ? {{(SW-8){mouse_dx[7]}}, mouse_dx} : '0;
    w_bstep   = w_bklR ? SW'(1) : (w_bklL ? {SW{1'b1}} : '0);
    w_sum     = w_pendExt - w_bstep + w_dxExt;
    if (w_sum > PMAX)
      w_pendNext = PMAX[CNT_W-1:0];
    else if (w_sum < PMIN)
      w_pendNext = PMIN[CNT_W-1:0];
    else
      w_pendNext = w_sum[CNT_W-1:0];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt     <= 8'd0;
      r_steer   <= 2'b00;
      r_pending <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_cnt     <= w_tick ? w_reload : r_cnt - 8'd1;
      r_steer   <= w_steerNext;
      r_pending <= w_pendNext;
      r_busy    <= (w_pendNext != '0) | w_joyR | w_joyL;
    end
  end

  assign steer   = r_steer;
  assign pending = r_pending;
  assign busy    = r_busy;

endmodule
